// File: rtl/seq_pkg.sv
// Shared definitions for the x/y/z serial pattern link: FSM states, line
// selection codes and default patterns agreed with the sequence detector.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SEL_X   = 2'b00,
        SEL_Y   = 2'b01,
        SEL_Z   = 2'b10,
        SEL_ALL = 2'b11
    } sel_t;

    localparam int unsigned PAT_W = 8;

    // Patterns are right-justified in PAT_W bits; the channel left-aligns them.
    localparam logic [PAT_W-1:0] X_PAT_DEF = 8'b0000_1010;
    localparam int unsigned      X_LEN_DEF = 4;
    localparam logic [PAT_W-1:0] Y_PAT_DEF = 8'b0000_0111;
    localparam int unsigned      Y_LEN_DEF = 3;
    localparam logic [PAT_W-1:0] Z_PAT_DEF = 8'b0000_0010;
    localparam int unsigned      Z_LEN_DEF = 2;

    function automatic logic [3:0] max3(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
        logic [3:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_shift_chan.sv
// One serial line: loads a pattern MSB-first and shifts it out one bit per
// clock; bits past the pattern length come out as zero.
module seq_shift_chan
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       length,
    output logic             bit_out
);

    logic [PAT_W-1:0] sr;
    logic [PAT_W-1:0] aligned;

    always_comb begin
        aligned = pattern << (4'd8 - length);
    end

    // The MSB goes straight to the output on load so the first bit appears
    // in the cycle after the request; any idle cycle forces the line low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_out <= 1'b0;
        end else if (load) begin
            bit_out <= aligned[PAT_W-1];
            sr      <= {aligned[PAT_W-2:0], 1'b0};
        end else if (shift_en) begin
            bit_out <= sr[PAT_W-1];
            sr      <= {sr[PAT_W-2:0], 1'b0};
        end else begin
            bit_out <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter for the x/y/z sequence detector: sends the
// selected pattern(s) rep times with a GAP-cycle idle gap between frames.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter logic [PAT_W-1:0] X_PAT = X_PAT_DEF,
    parameter int unsigned      X_LEN = X_LEN_DEF,
    parameter logic [PAT_W-1:0] Y_PAT = Y_PAT_DEF,
    parameter int unsigned      Y_LEN = Y_LEN_DEF,
    parameter logic [PAT_W-1:0] Z_PAT = Z_PAT_DEF,
    parameter int unsigned      Z_LEN = Z_LEN_DEF,
    parameter int unsigned      GAP   = 1,
    parameter int unsigned      REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       sel,
    input  logic [REP_W-1:0] rep,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0]       X_L     = 4'(X_LEN);
    localparam logic [3:0]       Y_L     = 4'(Y_LEN);
    localparam logic [3:0]       Z_L     = 4'(Z_LEN);
    localparam logic [3:0]       GAP_C   = 4'(GAP);
    localparam logic [REP_W-1:0] REP_ONE = 1;

    state_t           state_q, state_d;
    sel_t             sel_q, sel_d, sel_eff;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       last_q, last_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [3:0]       gap_q, gap_d;
    logic             busy_d, done_d, err_d;
    logic             load, shift_en;
    logic [3:0]       len_in;
    logic [PAT_W-1:0] x_pat, y_pat, z_pat;

    always_comb begin
        case (sel_t'(sel))
            SEL_X:   len_in = X_L;
            SEL_Y:   len_in = Y_L;
            SEL_Z:   len_in = Z_L;
            default: len_in = max3(X_L, Y_L, Z_L);
        endcase
    end

    // A load from IDLE uses the live sel; reloads between repetitions use the latched one.
    always_comb begin
        sel_eff = (state_q == ST_IDLE) ? sel_t'(sel) : sel_q;
        x_pat   = (sel_eff == SEL_X || sel_eff == SEL_ALL) ? X_PAT : '0;
        y_pat   = (sel_eff == SEL_Y || sel_eff == SEL_ALL) ? Y_PAT : '0;
        z_pat   = (sel_eff == SEL_Z || sel_eff == SEL_ALL) ? Z_PAT : '0;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        last_d   = last_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (rep == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d   = sel_t'(sel);
                        rep_d   = rep;
                        last_d  = 3'(len_in - 4'd1);
                        idx_d   = 3'(len_in - 4'd1);
                        load    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (idx_q != 3'd0) begin
                    idx_d    = idx_q - 3'd1;
                    shift_en = 1'b1;
                end else begin
                    rep_d = rep_q - REP_ONE;
                    if (rep_q != REP_ONE) begin
                        if (GAP_C != 4'd0) begin
                            gap_d   = GAP_C - 4'd1;
                            state_d = ST_GAP;
                        end else begin
                            load  = 1'b1;
                            idx_d = last_q;
                        end
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_q == 4'd0) begin
                    load    = 1'b1;
                    idx_d   = last_q;
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_X;
            idx_q   <= '0;
            last_q  <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    seq_shift_chan u_x (
        .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
        .pattern(x_pat), .length(X_L), .bit_out(x)
    );

    seq_shift_chan u_y (
        .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
        .pattern(y_pat), .length(Y_L), .bit_out(y)
    );

    seq_shift_chan u_z (
        .clk(clk), .reset(reset), .load(load), .shift_en(shift_en),
        .pattern(z_pat), .length(Z_L), .bit_out(z)
    );

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter. It is the driving end of the team's three-line sequence detector (lines x, y, z).
On a start request it shifts fixed bit patterns MSB-first, one bit per clock, onto the selected line(s). It can repeat a pattern back-to-back with a configurable idle gap.
Used as stimulus source and link-side transmitter for the detector, which matches x="1010", y="111", z="10".

Parameters:
X_PAT, 4'b1010, x-line pattern, MSB sent first
X_LEN, 4, bits in X_PAT (1..8)
Y_PAT, 3'b111, y-line pattern
Y_LEN, 3, bits in Y_PAT (1..8)
Z_PAT, 2'b10, z-line pattern
Z_LEN, 2, bits in Z_PAT (1..8)
GAP, 1, zero cycles inserted between repetitions (0..15)
REP_W, 4, width of repeat-count input

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  request, sampled only in IDLE
sel  in  2  00=x only, 01=y only, 10=z only, 11=all three in parallel
rep  in  REP_W  number of pattern repetitions; 0 is illegal
x  out  1  serial x line, registered
y  out  1  serial y line, registered
z  out  1  serial z line, registered
busy  out  1  high while bits or gaps are being sent
done  out  1  one-cycle pulse after the final bit
err  out  1  one-cycle pulse when start is sampled with rep==0

Behaviour:
- Reset, sampled at posedge: state=IDLE; x=y=z=0; busy=done=err=0; all counters cleared. Reset overrides every other input, including mid-frame.
- Frame length L:
  - sel=00: X_LEN. sel=01: Y_LEN. sel=10: Z_LEN.
  - sel=11: max of the three lengths. Each line is left-aligned (MSB first) and zero-padded after its own length.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - Lines held at 0.
  - start=1 and rep!=0 at edge T: latch sel, rep, L; bit index = L-1; go to SEND.
  - start=1 and rep==0: err=1 at T+1; stay IDLE.
- SEND:
  - The output register drives the current bit each cycle; index decrements.
  - The first bit is visible in cycle T+1 and busy rises in T+1.
  - Non-selected lines stay 0.
  - At index 0: decrement the repetition counter.
    - Remaining reps >0 and GAP>0: go to GAP.
    - Remaining reps >0 and GAP==0: reload the index and continue SEND with no bubble.
    - Otherwise: go to FIN.
- GAP: drive 0 on all lines, busy=1, for exactly GAP cycles; then reload the index and go to SEND.
- FIN: lines=0, busy=0, done=1 for exactly one cycle; go to IDLE. A start arriving in the FIN cycle is ignored.
- Completion timing: done is asserted in cycle T+1+R*L+(R-1)*GAP. A new start is accepted from the following edge.
- Request handling: start while busy is ignored and not queued. sel/rep changes while busy have no effect.
- Counters: rep counter is REP_W wide. Bit index is 3 bits. Gap counter is 4 bits. No wrap occurs: each counter reloads before reaching underflow.
- Registered outputs: all outputs come from registers; there is no combinational path from any input to any output.

Decomposition:
- Shared package seq_pkg:
  - state enum (IDLE, SEND, GAP, FIN)
  - sel codes (SEL_X, SEL_Y, SEL_Z, SEL_ALL)
  - default pattern/length constants shared with the detector, so both ends agree
- Sub-module seq_shift_chan, instantiated three times:
  - inputs: load, shift enable, pattern, length
  - output: registered serial bit, zero-padded past its length
- The top holds the FSM, repetition counter and gap counter.

Test Plan:
- Single x frame: reset, then start=1, sel=00, rep=1 at edge 10 -> x=1,0,1,0 in cycles 11-14; busy 11-14; done=1 in cycle 15 only; y=z=0 throughout.
- Parallel frame: sel=11, rep=1 at edge 20 -> cycles 21-24 carry x=1010, y=1110, z=1000; done in cycle 25.
- Repeat with gap: sel=01, rep=2, GAP=1 at edge 30 -> y=1,1,1,0,1,1,1 in cycles 31-37; done in cycle 38. Rerun with GAP=0 -> y=1 for cycles 31-36; done in cycle 37.
- Illegal and ignored requests:
  - rep=0 with start -> err pulse one cycle later; busy stays 0.
  - start while busy -> no effect on the frame or on done timing.
- Reset mid-frame: assert reset in the third bit cycle -> next cycle x=y=z=busy=done=0 and state is IDLE. A subsequent start produces a full, clean frame.
- Loopback: drive the detector with each sel value and rep=1 -> the detector output asserts once per frame, at the expected cycle.
